cmd_sequencer: RTL and testbench
================================

Name: cmd_sequencer

Overview:
- Controls the configuration register bank in the blinky top level.
- Consumes the byte stream from uart_rx and decodes fixed 6-byte frames: command, address, 4 value bytes big-endian.
- Issues register-bank writes and reads, then queues response bytes into the UART TX FIFO with backpressure.
- Is the only master of the register bank's host port.

Parameters:
- WIDTH, 8, UART byte width.
- REG_WIDTH, 32, register value width; must equal 4*WIDTH.
- ADDR_WIDTH, 4, register address width (16 registers).
- TIMEOUT_CYCLES, 500000, idle clocks allowed between bytes of one frame (10 ms at 50 MHz).
- READ_CMD, 8'h72, read command byte ('r').
- WRITE_CMD, 8'h77, write command byte ('w').

Ports:
- clk  in  1  system clock, 50 MHz.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  WIDTH  received byte from uart_rx.
- i_rx_dv  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- o_reg_we  out  1  register write strobe, one cycle.
- o_reg_re  out  1  register read strobe, one cycle.
- o_reg_addr  out  ADDR_WIDTH  register address for a write or read.
- o_reg_wdata  out  REG_WIDTH  write data.
- i_reg_rdata  in  REG_WIDTH  read data, valid exactly 1 cycle after o_reg_re.
- o_tx_w_en  out  1  TX FIFO write enable.
- o_tx_w_data  out  WIDTH  TX FIFO write data.
- i_tx_full  in  1  TX FIFO full.
- o_busy  out  1  high in every state except IDLE.
- o_err  out  1  one-cycle error pulse.

Behaviour:
- Reset (synchronous, i_reset high on a clk edge):
  - state=IDLE.
  - All strobes (o_reg_we, o_reg_re, o_tx_w_en, o_err) = 0.
  - o_reg_addr=0, o_reg_wdata=0, o_tx_w_data=0, o_busy=0.
  - Byte and timeout counters cleared.
  - Reset mid-frame or mid-response abandons everything; no partial response is sent.
- IDLE:
  - On i_rx_dv with READ_CMD or WRITE_CMD: latch the command, go to ADDR.
  - On i_rx_dv with any other byte: pulse o_err, queue NAK (8'h15), go to RESP. Following bytes are then parsed from IDLE.
- ADDR:
  - Next i_rx_dv latches the full 8-bit address byte; go to VAL with byte count 0.
- VAL:
  - Four i_rx_dv bytes shift into the value register MSB first.
  - After the 4th byte, go to CHECK.
  - Read frames also carry 4 value bytes; they are ignored.
- CHECK (one cycle):
  - Address byte >= 2**ADDR_WIDTH: pulse o_err, queue NAK, go to RESP.
  - Otherwise, write: o_reg_we=1 for one cycle with o_reg_addr=addr[ADDR_WIDTH-1:0] and o_reg_wdata=value; queue ACK (8'h06); go to RESP.
  - Otherwise, read: o_reg_re=1 for one cycle; go to RD_WAIT.
- RD_WAIT (one cycle):
  - Capture i_reg_rdata and queue 4 bytes, MSB first; go to RESP.
- RESP:
  - Each cycle with a queued byte and i_tx_full=0: o_tx_w_en=1 and o_tx_w_data=next byte.
  - With i_tx_full=1: no write, byte is held.
  - After the last byte is written, go to IDLE.
  - Latency: write ACK reaches the FIFO 2 clocks after the last rx strobe; read data reaches it 3 clocks after (first byte) when not full.
- Overrun: i_rx_dv in CHECK, RD_WAIT or RESP drops the byte and pulses o_err.
- Timeout:
  - In ADDR/VAL, a counter clears on each i_rx_dv and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1: pulse o_err, go to IDLE, no response sent.
- Simultaneous events: an i_rx_dv on the timeout cycle is accepted and the counter clears; the timeout does not fire.

Optional Feature:
- Macro: CMD_SEQ_WRITE_READBACK_EN.
- Defined: after a write, the block goes CHECK -> RD_WAIT (o_reg_re issued 1 cycle after o_reg_we, same address). It responds with the 4 read-back bytes MSB first instead of ACK. Write-response latency grows by 2 cycles.
- Undefined: a write responds with a single ACK byte.

Decomposition:
- Package cmd_seq_pkg holds:
  - state enum {IDLE, ADDR, VAL, CHECK, RD_WAIT, RESP}.
  - READ_CMD, WRITE_CMD, ACK=8'h06, NAK=8'h15.
  - FRAME_VALUE_BYTES=4.
- Sub-module cmd_resp_serializer:
  - Loads 1 or 4 bytes plus a count; drains them into the FIFO honoring i_tx_full.
  - Asserts a done strobe when empty.
  - The FSM stays in cmd_sequencer.

Test Plan:
- Write: bytes 77 03 DE AD BE EF, FIFO not full -> one o_reg_we with addr=3 and wdata=32'hDEADBEEF; tx byte 06; o_err never asserted.
- Read: preload reg 10 = 32'h0000000A; bytes 72 0A 00 00 00 00 -> one o_reg_re with addr=10; tx bytes 00 00 00 0A in order.
- Backpressure: read of reg 10 with i_tx_full held high for 20 clocks after RD_WAIT -> no o_tx_w_en while full; then 4 consecutive writes, correct order, no loss.
- Errors:
  - byte 41 in IDLE -> o_err pulse and tx 15.
  - frame 77 20 00 00 00 01 -> no o_reg_we, tx 15.
- Timeout: send 77 05, then idle TIMEOUT_CYCLES clocks -> o_err pulse and IDLE; subsequent full frame 77 05 00 00 00 07 writes 7 to reg 5.
- Reset mid-RESP: during a 4-byte read response, assert i_reset after 2 bytes -> remaining bytes never written; o_busy=0 next cycle.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// Shared constants for the command sequencer: command/response bytes,
// frame geometry and FSM state encodings.
package cmd_seq_pkg;

  localparam logic [7:0] READ_CMD  = 8'h72;
  localparam logic [7:0] WRITE_CMD = 8'h77;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  localparam int FRAME_VALUE_BYTES = 4;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR    = 3'd1;
  localparam logic [2:0] VAL     = 3'd2;
  localparam logic [2:0] CHECK   = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

endpackage

// File: rtl/cmd_sequencer_if.sv
// Register-bank host port plus TX FIFO write port driven by cmd_sequencer.
// The master side is the sequencer; the slave side is the bank and FIFO.
interface cmd_sequencer_if #(
  parameter int WIDTH      = 8,
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 4
);

  logic                  reg_we;
  logic                  reg_re;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [REG_WIDTH-1:0]  reg_wdata;
  logic [REG_WIDTH-1:0]  reg_rdata;
  logic                  tx_w_en;
  logic [WIDTH-1:0]      tx_w_data;
  logic                  tx_full;

  modport master (
    output reg_we, reg_re, reg_addr, reg_wdata,
    input  reg_rdata,
    output tx_w_en, tx_w_data,
    input  tx_full
  );

  modport slave (
    input  reg_we, reg_re, reg_addr, reg_wdata,
    output reg_rdata,
    input  tx_w_en, tx_w_data,
    output tx_full
  );

endinterface

// File: rtl/cmd_resp_serializer.sv
// Response serializer: loads one or four bytes (left-aligned, MSB first)
// and drains them into the TX FIFO whenever it is not full. o_done pulses
// on the cycle the final byte is written.
module cmd_resp_serializer #(
  parameter int WIDTH     = 8,
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic [2:0]           i_count,
  input  logic [REG_WIDTH-1:0] i_data,
  input  logic                 i_tx_full,
  output logic                 o_tx_w_en,
  output logic [WIDTH-1:0]     o_tx_w_data,
  output logic                 o_done
);

  logic [REG_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]           count_q, count_d;

  assign o_tx_w_en   = (count_q != 3'd0) && !i_tx_full;
  assign o_tx_w_data = shift_q[REG_WIDTH-1 -: WIDTH];
  assign o_done      = o_tx_w_en && (count_q == 3'd1);

  // Load a new response or shift out the head byte once the FIFO takes it.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (i_load) begin
      shift_d = i_data;
      count_d = i_count;
    end else if (o_tx_w_en) begin
      shift_d = shift_q << WIDTH;
      count_d = count_q - 3'd1;
    end
  end

  // Queue storage; reset discards any partly sent response.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// UART command sequencer: decodes 6-byte frames (cmd, addr, 4 value bytes
// big-endian), drives the register-bank host port and queues responses.
// Optional macro CMD_SEQ_WRITE_READBACK_EN: a write is followed by a
// read of the same register and the 4 read-back bytes replace the ACK.
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int                 WIDTH          = 8,
  parameter int                 REG_WIDTH      = 32,
  parameter int                 ADDR_WIDTH     = 4,
  parameter int                 TIMEOUT_CYCLES = 500000,
  parameter logic [WIDTH-1:0]   READ_CMD       = cmd_seq_pkg::READ_CMD,
  parameter logic [WIDTH-1:0]   WRITE_CMD      = cmd_seq_pkg::WRITE_CMD
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic [WIDTH-1:0]    i_rx_data,
  input  logic                i_rx_dv,
  cmd_sequencer_if.master     bus,
  output logic                o_busy,
  output logic                o_err
);

  localparam int TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(FRAME_VALUE_BYTES - 1);
  localparam int            ADDR_LIMIT = 2 ** ADDR_WIDTH;

  logic [2:0]           state_q, state_d;
  logic                 is_write_q, is_write_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [REG_WIDTH-1:0] value_q, value_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 rb_q, rb_d;

  logic                 reg_we, reg_re;
  logic                 load;
  logic [2:0]           load_count;
  logic [REG_WIDTH-1:0] load_data;
  logic                 ser_done;

  assign bus.reg_we    = reg_we;
  assign bus.reg_re    = reg_re;
  assign bus.reg_addr  = addr_q[ADDR_WIDTH-1:0];
  assign bus.reg_wdata = value_q;
  assign o_busy        = (state_q != IDLE);
  assign o_err         = err_q;

  cmd_resp_serializer #(
    .WIDTH     (WIDTH),
    .REG_WIDTH (REG_WIDTH)
  ) u_serializer (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_load      (load),
    .i_count     (load_count),
    .i_data      (load_data),
    .i_tx_full   (bus.tx_full),
    .o_tx_w_en   (bus.tx_w_en),
    .o_tx_w_data (bus.tx_w_data),
    .o_done      (ser_done)
  );

  // Frame decode FSM: collects bytes, issues bank accesses, queues replies.
  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    value_d    = value_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    rb_d       = rb_q;
    err_d      = 1'b0;
    reg_we     = 1'b0;
    reg_re     = 1'b0;
    load       = 1'b0;
    load_count = 3'd1;
    load_data  = {NAK, {(REG_WIDTH-WIDTH){1'b0}}};

    case (state_q)
      IDLE: begin
        if (i_rx_dv) begin
          if (i_rx_data == READ_CMD || i_rx_data == WRITE_CMD) begin
            is_write_d = (i_rx_data == WRITE_CMD);
            tmo_d      = '0;
            state_d    = ADDR;
          end else begin
            err_d   = 1'b1;
            load    = 1'b1;
            state_d = RESP;
          end
        end
      end
      ADDR: begin
        if (i_rx_dv) begin
          addr_d     = i_rx_data;
          byte_cnt_d = '0;
          tmo_d      = '0;
          state_d    = VAL;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      VAL: begin
        if (i_rx_dv) begin
          value_d = {value_q[REG_WIDTH-WIDTH-1:0], i_rx_data};
          tmo_d   = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = CHECK;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CHECK: begin
        err_d = i_rx_dv;
        if (int'(addr_q) >= ADDR_LIMIT) begin
          err_d   = 1'b1;
          load    = 1'b1;
          state_d = RESP;
        end else if (is_write_q) begin
          reg_we = 1'b1;
`ifdef CMD_SEQ_WRITE_READBACK_EN
          rb_d    = 1'b1;
          state_d = RD_WAIT;
`else
          load      = 1'b1;
          load_data = {ACK, {(REG_WIDTH-WIDTH){1'b0}}};
          state_d   = RESP;
`endif
        end else begin
          reg_re  = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        err_d = i_rx_dv;
        if (rb_q) begin
          reg_re = 1'b1;
          rb_d   = 1'b0;
        end else begin
          load       = 1'b1;
          load_count = 3'd4;
          load_data  = bus.reg_rdata;
          state_d    = RESP;
        end
      end
      RESP: begin
        err_d = i_rx_dv;
        if (ser_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and frame registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      value_q    <= '0;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      rb_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      value_q    <= value_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      rb_q       <= rb_d;
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed testbench for cmd_sequencer with a behavioural register bank.
// Honours CMD_SEQ_WRITE_READBACK_EN when computing write responses.
module tb_cmd_sequencer;
  import cmd_seq_pkg::*;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic       busy;
  logic       err;

  cmd_sequencer_if #(.WIDTH(8), .REG_WIDTH(32), .ADDR_WIDTH(4)) bus();

  cmd_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .i_reset   (reset),
    .i_rx_data (rx_data),
    .i_rx_dv   (rx_dv),
    .bus       (bus),
    .o_busy    (busy),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];

  // Register bank: writes land on the edge, read data valid one cycle after re.
  always @(posedge clk) begin
    if (bus.reg_we === 1'b1) mem[bus.reg_addr] <= bus.reg_wdata;
    if (bus.reg_re === 1'b1) bus.reg_rdata <= mem[bus.reg_addr];
  end

  int          cyc = 0, we_cnt = 0, re_cnt = 0, err_cnt = 0, ovf_cnt = 0, last_dv_cyc = 0;
  logic [3:0]  last_we_addr, last_re_addr;
  logic [31:0] last_wdata;
  logic [7:0]  txq[$];
  int          txcyc[$];

  // Observe strobes and FIFO writes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rx_dv === 1'b1) last_dv_cyc = cyc;
    if (bus.reg_we === 1'b1) begin
      we_cnt++;
      last_we_addr = bus.reg_addr;
      last_wdata   = bus.reg_wdata;
    end
    if (bus.reg_re === 1'b1) begin
      re_cnt++;
      last_re_addr = bus.reg_addr;
    end
    if (err === 1'b1) err_cnt++;
    if (bus.tx_w_en === 1'b1) begin
      if (bus.tx_full !== 1'b0) ovf_cnt++;
      txq.push_back(bus.tx_w_data);
      txcyc.push_back(cyc);
    end
  end

  int total = 0, bad = 0;
  int txp = 0;
  int b_we, b_re, b_err;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_dv = 1'b1;
    @(posedge clk);
    #1 rx_dv = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] v);
    applyStimulus(c);
    applyStimulus(a);
    applyStimulus(v[31:24]);
    applyStimulus(v[23:16]);
    applyStimulus(v[15:8]);
    applyStimulus(v[7:0]);
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    checkOutput({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic markBase();
    b_we  = we_cnt;
    b_re  = re_cnt;
    b_err = err_cnt;
  endtask

  task automatic checkResp(input string tag, input int n, input logic [31:0] exp, input int lat);
    int avail;
    avail = txq.size() - txp;
    checkOutput({tag, "_count"}, avail, n);
    if (lat >= 0 && avail > 0) checkOutput({tag, "_lat"}, txcyc[txp] - last_dv_cyc, lat);
    for (int i = 0; i < n && i < avail; i++)
      checkOutput($sformatf("%s_b%0d", tag, i), {24'b0, txq[txp+i]},
                  {24'b0, (n == 1) ? exp[7:0] : exp[31-8*i -: 8]});
    txp = txq.size();
  endtask

  task automatic checkWrite(input string tag, input logic [3:0] a, input logic [31:0] v);
    checkOutput({tag, "_we"}, we_cnt - b_we, 1);
    checkOutput({tag, "_addr"}, {28'b0, last_we_addr}, {28'b0, a});
    checkOutput({tag, "_wdata"}, last_wdata, v);
    checkOutput({tag, "_err"}, err_cnt - b_err, 0);
`ifdef CMD_SEQ_WRITE_READBACK_EN
    checkResp({tag, "_resp"}, 4, v, 4);
`else
    checkResp({tag, "_resp"}, 1, 32'h06, 2);
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    rx_dv = 1'b0;
    rx_data = '0;
    bus.tx_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_err", {31'b0, err}, 0);
    checkOutput("rst_we", {31'b0, bus.reg_we}, 0);
    checkOutput("rst_re", {31'b0, bus.reg_re}, 0);
    checkOutput("rst_tx_en", {31'b0, bus.tx_w_en}, 0);
    checkOutput("rst_addr", {28'b0, bus.reg_addr}, 0);
    checkOutput("rst_wdata", bus.reg_wdata, 0);
    checkOutput("rst_txdata", {24'b0, bus.tx_w_data}, 0);

    $display("[TB] write reg 3");
    markBase();
    sendFrame(8'h77, 8'h03, 32'hDEADBEEF);
    waitIdle("wr3");
    checkWrite("wr3", 4'd3, 32'hDEADBEEF);

    $display("[TB] write then read reg 10");
    markBase();
    sendFrame(8'h77, 8'h0A, 32'h0000000A);
    waitIdle("wr10");
    checkWrite("wr10", 4'd10, 32'h0000000A);
    markBase();
    sendFrame(8'h72, 8'h0A, 32'h00000000);
    waitIdle("rd10");
    checkOutput("rd10_re", re_cnt - b_re, 1);
    checkOutput("rd10_addr", {28'b0, last_re_addr}, 32'd10);
    checkOutput("rd10_we", we_cnt - b_we, 0);
    checkResp("rd10_resp", 4, 32'h0000000A, 3);

    $display("[TB] backpressure with overrun byte");
    markBase();
    bus.tx_full = 1'b1;
    sendFrame(8'h72, 8'h0A, 32'h11223344);
    repeat (4) @(posedge clk);
    applyStimulus(8'h55);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("bp_held", txq.size() - txp, 0);
    checkOutput("bp_busy", {31'b0, busy}, 1);
    checkOutput("bp_overrun_err", err_cnt - b_err, 1);
    @(posedge clk);
    #1 bus.tx_full = 1'b0;
    waitIdle("bp");
    if (txq.size() - txp >= 4) checkOutput("bp_consecutive", txcyc[txp+3] - txcyc[txp], 3);
    checkResp("bp_resp", 4, 32'h0000000A, -1);
    checkOutput("bp_no_write_when_full", ovf_cnt, 0);

    $display("[TB] bad command byte");
    markBase();
    applyStimulus(8'h41);
    waitIdle("badcmd");
    checkOutput("badcmd_err", err_cnt - b_err, 1);
    checkResp("badcmd_resp", 1, 32'h15, -1);

    $display("[TB] out-of-range address");
    markBase();
    sendFrame(8'h77, 8'h20, 32'h00000001);
    waitIdle("badaddr");
    checkOutput("badaddr_we", we_cnt - b_we, 0);
    checkOutput("badaddr_err", err_cnt - b_err, 1);
    checkResp("badaddr_resp", 1, 32'h15, -1);

    $display("[TB] timeout");
    markBase();
    applyStimulus(8'h77);
    applyStimulus(8'h05);
    repeat (TMO - 3) @(negedge clk);
    checkOutput("tmo_not_early", {31'b0, busy}, 1);
    repeat (8) @(negedge clk);
    checkOutput("tmo_busy", {31'b0, busy}, 0);
    checkOutput("tmo_err", err_cnt - b_err, 1);
    checkOutput("tmo_no_resp", txq.size() - txp, 0);
    checkOutput("tmo_no_we", we_cnt - b_we, 0);
    markBase();
    sendFrame(8'h77, 8'h05, 32'h00000007);
    waitIdle("wr5");
    checkWrite("wr5", 4'd5, 32'h00000007);

    $display("[TB] byte on the timeout cycle is accepted");
    markBase();
    applyStimulus(8'h77);
    repeat (TMO - 2) @(posedge clk);
    applyStimulus(8'h06);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    applyStimulus(8'h78);
    waitIdle("edge");
    checkWrite("edge", 4'd6, 32'h12345678);

    $display("[TB] reset during read response");
    markBase();
    bus.tx_full = 1'b1;
    sendFrame(8'h72, 8'h03, 32'h00000000);
    repeat (5) @(posedge clk);
    #1 bus.tx_full = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_busy", {31'b0, busy}, 0);
    repeat (10) @(negedge clk);
    checkOutput("rstmid_count", txq.size() - txp, 2);
    if (txq.size() - txp >= 2) begin
      checkOutput("rstmid_b0", {24'b0, txq[txp]}, 32'hDE);
      checkOutput("rstmid_b1", {24'b0, txq[txp+1]}, 32'hAD);
    end
    txp = txq.size();

    $display("[TB] read after recovery");
    markBase();
    sendFrame(8'h72, 8'h05, 32'h00000000);
    waitIdle("rd5");
    checkResp("rd5_resp", 4, 32'h00000007, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
